layer_mem_reader: RTL and testbench
===================================

Name: layer_mem_reader

Overview:
- Read-side counterpart of the layer write path. Streams one stored layer result region (e.g. the max-pooled layer-1 image) back out of the external layer memory, word by word, in ascending address order.
- Drives the memory read interface and presents data on a valid/ready stream toward downstream consumers (next layer or result checker).
- Buffers read data in a 2-entry FIFO so downstream backpressure never loses a returned word.

Parameters:
- DATA_W, 20, width of a memory word and of the output stream.
- ADDR_W, 12, memory address width.
- DEPTH, 1024, number of words read per run.
- BASE, 0, first address read; addresses are BASE..BASE+DEPTH-1, modulo 2^ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle request to begin a run; ignored while o_busy=1.
- i_sel  in  3  memory select for the run; latched when i_start is accepted.
- o_busy  out  1  high from accepted start until the last word is popped.
- o_rd  out  1  memory read strobe, registered.
- o_addr  out  ADDR_W  read address, registered.
- o_sel  out  3  memory select, registered; holds the latched i_sel while busy.
- i_data  in  DATA_W  memory read data, valid at the first clock edge after an edge where o_rd=1.
- o_valid  out  1  stream data valid (FIFO not empty).
- o_data  out  DATA_W  stream data (FIFO head).
- o_last  out  1  high with o_valid when the head word is index DEPTH-1.
- i_ready  in  1  downstream accepts; a pop occurs on an edge where o_valid && i_ready.

Behaviour:
- Reset (reset=0 at an edge) forces all of the following, regardless of current state, including mid-run:
  - o_busy=0, o_rd=0, o_addr=0, o_sel=0, o_valid=0, o_data=0, o_last=0.
  - FIFO emptied, inflight cleared, counters zeroed, FSM to IDLE.
- FSM states:
  - IDLE: waits for i_start.
  - READ: issuing reads.
  - DRAIN: all reads issued; waiting for the FIFO to empty.
- Transitions:
  - IDLE -> READ on the edge sampling i_start=1. At that edge: latch i_sel into o_sel, set o_addr=BASE, o_rd=1, o_busy=1, issue count=1, rd_idx=0.
  - READ -> DRAIN on the edge that issues read number DEPTH; o_rd drops after that edge.
  - DRAIN -> IDLE on the edge that pops the word with o_last=1; o_busy=0 after that edge.
- Read latency: exactly 1 cycle. When o_rd=1 at edge En, i_data is captured into the FIFO at En+1. `inflight` is 1 during that cycle.
- Credit rule: at each edge in READ, issue the next read (o_rd=1, o_addr+1 mod 2^ADDR_W) only if fifo_count + inflight - pop <= 1, using the values before the edge. Otherwise o_rd=0 and o_addr holds. Never more than 2 words are held plus in flight.
- Throughput: with i_ready held high, one read per cycle and one pop per cycle. The first o_valid appears one cycle after the first o_rd cycle.
- FIFO:
  - Simultaneous push and pop at count=2 cannot occur under the credit rule.
  - Push and pop in the same edge at count=1 keeps count=1 and the head advances.
  - o_data/o_last stay stable while o_valid && !i_ready.
- o_last is computed from a per-word index carried alongside the data in the FIFO, not from o_addr.
- i_start while o_busy=1 is ignored; i_sel is not relatched.
- Address wrap: BASE+DEPTH beyond 2^ADDR_W wraps to 0 with no error.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W.
  - Select codes: SEL_NONE=0, SEL_L0=1, SEL_L1=3, SEL_L2=5.
  - The FSM state encoding: IDLE=2'd0, READ=2'd1, DRAIN=2'd2.
- One sub-module, mem_rd_fifo2: a 2-entry FIFO of {last, data} with push, pop, count[1:0] and head outputs. The credit logic stays in the parent.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with i_start=1 -> all outputs 0, no o_rd. Release -> still idle until i_start is sampled.
- Basic run (DEPTH=4, BASE=10, memory returns addr*3, i_ready=1, i_sel=3):
  - o_rd high for 4 consecutive cycles with o_addr 10,11,12,13 and o_sel=3.
  - o_data 30,33,36,39 on consecutive cycles; o_last only with 39.
  - o_busy falls the edge after 39 is popped.
- Backpressure (DEPTH=6, i_ready=0 for 8 cycles after start):
  - Exactly 2 reads issued, then o_rd=0 and o_addr held.
  - o_valid=1 with o_data stable at the first word.
  - After i_ready=1, all 6 words arrive in order with none lost or duplicated.
- Start while busy: pulse i_start with i_sel=5 mid-run -> o_sel unchanged, address sequence and word count unaffected.
- Reset mid-run: reset=0 after the 2nd read with 1 word in the FIFO -> next cycle o_valid=0, o_rd=0, o_busy=0. A new start then reads again from BASE.
- Wrap (BASE=4094, DEPTH=4): o_addr sequence 4094,4095,0,1; o_last on the 4th word.

Source files
------------

// File: rtl/layer_mem_reader_pkg.sv
// Shared widths, memory select codes and FSM encoding for the layer memory read path.
package layer_mem_reader_pkg;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_L0   = 3'd1;
  localparam logic [2:0] SEL_L1   = 3'd3;
  localparam logic [2:0] SEL_L2   = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
endpackage

// File: rtl/layer_mem_reader_if.sv
// Memory read bus plus the valid/ready output stream of the layer memory reader.
interface layer_mem_reader_if #(
  parameter int DATA_W = layer_mem_reader_pkg::DATA_W,
  parameter int ADDR_W = layer_mem_reader_pkg::ADDR_W
);
  logic              o_rd;
  logic [ADDR_W-1:0] o_addr;
  logic [2:0]        o_sel;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              i_ready;

  modport master (
    output o_rd, o_addr, o_sel, o_valid, o_data, o_last,
    input  i_data, i_ready
  );

  modport slave (
    input  o_rd, o_addr, o_sel, o_valid, o_data, o_last,
    output i_data, i_ready
  );
endinterface

// File: rtl/mem_rd_fifo2.sv
// Two-entry FIFO holding returned memory words tagged with their last-word flag.
module mem_rd_fifo2 #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);
  logic [W-1:0] mem_q [2];
  logic         rptr_q, wptr_q;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && (count_q != 2'd2);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
endmodule

// File: rtl/layer_mem_reader.sv
// Streams DEPTH words from BASE upward out of the layer memory onto a valid/ready stream,
// throttling reads so returned words always fit in the 2-entry FIFO.
module layer_mem_reader #(
  parameter int DATA_W = layer_mem_reader_pkg::DATA_W,
  parameter int ADDR_W = layer_mem_reader_pkg::ADDR_W,
  parameter int DEPTH  = 1024,
  parameter int BASE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [2:0]         i_sel,
  output logic               o_busy,
  layer_mem_reader_if.master bus
);
  import layer_mem_reader_pkg::*;

  localparam int                IDX_W    = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          sel_q, sel_d;
  logic [IDX_W-1:0]    issued_q, issued_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;

  logic                push, pop, start_ok, credit_ok;
  logic [1:0]          fifo_cnt;
  logic [DATA_W:0]     fifo_head;
  logic [2:0]          occ;

  // A read on the bus this cycle is the in-flight word; it lands in the FIFO at the next edge.
  assign push      = rd_q;
  assign pop       = bus.o_valid && bus.i_ready;
  assign start_ok  = (state_q == ST_IDLE) && i_start;
  assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_q} - {2'b00, pop};
  assign credit_ok = (occ <= 3'd1);

  mem_rd_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({rd_idx_q == LAST_IDX, bus.i_data}),
    .count_o(fifo_cnt),
    .head_o (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    sel_d    = sel_q;
    issued_d = issued_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d  = (DEPTH == 1) ? ST_DRAIN : ST_READ;
          busy_d   = 1'b1;
          rd_d     = 1'b1;
          addr_d   = BASE_A;
          sel_d    = i_sel;
          issued_d = IDX_W'(1);
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          rd_d     = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + IDX_W'(1);
          if (issued_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifo_head[DATA_W]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_idx_d = rd_idx_q;
    if (start_ok)  rd_idx_d = '0;
    else if (push) rd_idx_d = rd_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= SEL_NONE;
      issued_q <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      issued_q <= issued_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  assign o_busy      = busy_q;
  assign bus.o_rd    = rd_q;
  assign bus.o_addr  = addr_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_valid = (fifo_cnt != 2'd0);
  assign bus.o_data  = fifo_head[DATA_W-1:0];
  assign bus.o_last  = bus.o_valid && fifo_head[DATA_W];
endmodule

// File: tb/tb_layer_mem_reader.sv
// Scoreboard bench: three reader instances (basic, backpressure, address wrap) share clk/reset.
module tb_layer_mem_reader;
  import layer_mem_reader_pkg::*;

  logic clk;
  logic reset;

  logic        start_r [3];
  logic [2:0]  sel_r   [3];
  logic        ready_r [3];
  logic        busy_w  [3];
  logic        rd_w    [3];
  logic [11:0] addr_w  [3];
  logic [2:0]  sel_w   [3];
  logic        valid_w [3];
  logic [19:0] data_w  [3];
  logic        last_w  [3];

  logic [11:0] exp_a [3][$];
  logic [20:0] exp_d [3][$];
  logic [2:0]  exp_sel [3];

  int total;
  int bad;

  function automatic int base_of(input int k);
    return (k == 0) ? 10 : (k == 1) ? 100 : 4094;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 1) ? 6 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BG = (g == 0) ? 10 : (g == 1) ? 100 : 4094;
    localparam int DG = (g == 1) ? 6 : 4;
    layer_mem_reader_if #(.DATA_W(20), .ADDR_W(12)) bus ();
    layer_mem_reader #(.DATA_W(20), .ADDR_W(12), .DEPTH(DG), .BASE(BG)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .i_start(start_r[g]),
      .i_sel  (sel_r[g]),
      .o_busy (busy_w[g]),
      .bus    (bus)
    );
    // Memory returns addr*3 while read is strobed, junk otherwise.
    assign bus.i_data  = bus.o_rd ? 20'(32'(bus.o_addr) * 3) : 20'hABCDE;
    assign bus.i_ready = ready_r[g];
    assign rd_w[g]     = bus.o_rd;
    assign addr_w[g]   = bus.o_addr;
    assign sel_w[g]    = bus.o_sel;
    assign valid_w[g]  = bus.o_valid;
    assign data_w[g]   = bus.o_data;
    assign last_w[g]   = bus.o_last;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every read strobe and every stream transfer.
  initial begin : monitor
    logic        hold_v [3];
    logic [20:0] hold_d [3];
    logic        busy_chk [3];
    int          iss [3];
    int          pops [3];
    logic [11:0] ea;
    logic [20:0] ed;
    for (int k = 0; k < 3; k++) begin
      hold_v[k] = 0; busy_chk[k] = 0; iss[k] = 0; pops[k] = 0; hold_d[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!reset) begin
          hold_v[k] = 0; busy_chk[k] = 0; iss[k] = 0; pops[k] = 0;
        end else begin
          if (busy_chk[k]) begin
            check("busy_fall", 64'(busy_w[k]), 64'd0);
            busy_chk[k] = 0;
          end
          if (hold_v[k])
            check("hold", {valid_w[k], last_w[k], data_w[k]}, {1'b1, hold_d[k]});
          if (rd_w[k]) begin
            iss[k]++;
            if (exp_a[k].size() == 0) check("rd_extra", 64'd1, 64'd0);
            else begin
              ea = exp_a[k].pop_front();
              check("addr", 64'(addr_w[k]), 64'(ea));
              check("sel", 64'(sel_w[k]), 64'(exp_sel[k]));
            end
            check("credit", 64'(iss[k] - pops[k] <= 2), 64'd1);
          end
          if (valid_w[k] && ready_r[k]) begin
            pops[k]++;
            if (exp_d[k].size() == 0) check("pop_extra", 64'd1, 64'd0);
            else begin
              ed = exp_d[k].pop_front();
              check("word", {last_w[k], data_w[k]}, 64'(ed));
              if (ed[20]) busy_chk[k] = 1;
            end
          end
          hold_v[k] = valid_w[k] && !ready_r[k];
          hold_d[k] = {last_w[k], data_w[k]};
        end
      end
    end
  end

  task automatic push_expect(input int k, input logic [2:0] s);
    int a;
    for (int i = 0; i < depth_of(k); i++) begin
      a = (base_of(k) + i) % 4096;
      exp_a[k].push_back(12'(a));
      exp_d[k].push_back({(i == depth_of(k) - 1), 20'(a * 3)});
    end
    exp_sel[k] = s;
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low for 8 cycles then high.
  task automatic run(input int k, input logic [2:0] s, input int mode, input int poke);
    int cyc;
    int rds;
    push_expect(k, s);
    start_r[k] = 1'b1;
    sel_r[k]   = s;
    ready_r[k] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #1;
    start_r[k] = 1'b0;
    cyc = 0;
    rds = 1;
    while (busy_w[k] && cyc < 200) begin
      if (mode == 2 && cyc == 8) begin
        check("bp_reads", 64'(rds), 64'd2);
        check("bp_addr_held", 64'(addr_w[k]), 64'((base_of(k) + 1) % 4096));
        check("bp_head", {valid_w[k], last_w[k], data_w[k]}, {2'b10, 20'(base_of(k) * 3)});
      end
      if (cyc > 0 && rd_w[k]) rds++;
      ready_r[k] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 3) != 0) : 1'(cyc >= 8);
      start_r[k] = (cyc == poke);
      if (cyc == poke) sel_r[k] = SEL_L2;
      @(posedge clk); #1;
      cyc++;
    end
    start_r[k] = 1'b0;
    ready_r[k] = 1'b1;
    check("timeout", 64'(cyc < 200), 64'd1);
    if (mode == 0) check("cycles", 64'(cyc), 64'(depth_of(k) + 1));
    @(negedge clk);
    check("words_left", 64'(exp_d[k].size()), 64'd0);
    check("reads_left", 64'(exp_a[k].size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [2:0] codes [4];
    codes[0] = SEL_NONE; codes[1] = SEL_L0; codes[2] = SEL_L1; codes[3] = SEL_L2;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_r[k] = 1'b1; sel_r[k] = 3'd7; ready_r[k] = 1'b1; exp_sel[k] = SEL_NONE;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check("reset_outputs", {busy_w[k], rd_w[k], addr_w[k], sel_w[k], valid_w[k], data_w[k], last_w[k]}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) start_r[k] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("idle_after_reset", {busy_w[k], rd_w[k], valid_w[k]}, 64'd0);
    @(posedge clk); #1;

    run(0, SEL_L1, 0, -1);
    run(1, SEL_L0, 2, -1);
    run(0, SEL_L0, 1, 2);

    // Reset while a run is in flight: second read out, one word already buffered.
    push_expect(0, SEL_L0);
    start_r[0] = 1'b1; sel_r[0] = SEL_L0; ready_r[0] = 1'b0;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_state", {busy_w[0], rd_w[0], valid_w[0]}, 64'b111);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_reset", {busy_w[0], rd_w[0], valid_w[0]}, 64'd0);
    exp_a[0].delete();
    exp_d[0].delete();
    @(posedge clk); #1;
    reset = 1'b1;
    ready_r[0] = 1'b1;
    @(posedge clk); #1;
    run(0, SEL_L2, 0, -1);

    run(2, SEL_L1, 1, -1);

    for (int n = 0; n < 8; n++)
      run($urandom_range(0, 2), codes[$urandom_range(0, 3)], 1,
          ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
